// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer
//   Steps the select of an external 4:1 mux through 0..3 and holds each
//   select for HOLD cycles. On the last hold cycle it samples the mux output.
//   The samples are sent out serially and also reassembled into a word. The
//   block flags any sample that differs from the captured data.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start, din      scan request and the word to scan (captured in IDLE)
//   mux_out         mux output (combinational from mux_in/sel)
//   mux_in, sel     registered mux data and select
//   busy            high in RUN and DONE
//   ser_out/valid   sampled bit and its one-cycle qualifier
//   word_out        reassembled word, updated on each DONE
//   done            one-cycle completion pulse
//   err             sticky sample mismatch flag
module mux_sel_sequencer #(
  parameter int HOLD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] din,
  input  logic       mux_out,
  output logic [3:0] mux_in,
  output logic [1:0] sel,
  output logic       busy,
  output logic       ser_out,
  output logic       ser_valid,
  output logic [3:0] word_out,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_mux_in, r_asm, r_word_out, r_hold_cnt;
  logic [1:0] r_sel;
  logic       r_ser_out, r_ser_valid, r_done, r_err;
  logic       w_accept, w_sample, w_last;
  logic [3:0] w_asm_nxt;

  assign w_accept = (r_state == IDLE) && start;
  assign w_sample = (r_state == RUN) && (r_hold_cnt == HOLD_M1);
  assign w_last   = w_sample && (r_sel == 2'd3);

  // Assembly register with the current sample merged in, so the final
  // sample is already included in word_out during the DONE cycle.
  always_comb begin
    w_asm_nxt        = r_asm;
    w_asm_nxt[r_sel] = mux_out;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mux_in    <= '0;
      r_sel       <= '0;
      r_hold_cnt  <= '0;
      r_asm       <= '0;
      r_word_out  <= '0;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_ser_valid <= 1'b0;
      r_done      <= 1'b0;
      if (w_accept) begin
        r_mux_in   <= din;
        r_sel      <= '0;
        r_hold_cnt <= '0;
        r_asm      <= '0;
        r_err      <= 1'b0;
      end else if (r_state == RUN) begin
        if (w_sample) begin
          r_hold_cnt  <= '0;
          r_ser_out   <= mux_out;
          r_ser_valid <= 1'b1;
          r_asm       <= w_asm_nxt;
          // 2-bit select wraps 3 -> 0 on its own
          r_sel       <= r_sel + 2'd1;
          if (mux_out != r_mux_in[r_sel]) r_err <= 1'b1;
          if (w_last) begin
            r_word_out <= w_asm_nxt;
            r_done     <= 1'b1;
          end
        end else begin
          r_hold_cnt <= r_hold_cnt + 4'd1;
        end
      end
    end
  end

  assign mux_in    = r_mux_in;
  assign sel       = r_sel;
  assign busy      = (r_state != IDLE);
  assign ser_out   = r_ser_out;
  assign ser_valid = r_ser_valid;
  assign word_out  = r_word_out;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: one instance with HOLD=1 and one with HOLD=3.
// Expected samples and words are queued when a scan is launched. They are
// compared against what the DUT reports during the scan.
module tb_mux_sel_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // HOLD=1 instance
  logic       start1 = 1'b0, force0 = 1'b0;
  logic [3:0] din1 = '0, mux_in1, word_out1;
  logic [1:0] sel1;
  logic       mux_out1, busy1, ser_out1, ser_valid1, done1, err1;
  assign mux_out1 = force0 ? 1'b0 : mux_in1[sel1];

  // HOLD=3 instance
  logic       start3 = 1'b0;
  logic [3:0] din3 = '0, mux_in3, word_out3;
  logic [1:0] sel3;
  logic       mux_out3, busy3, ser_out3, ser_valid3, done3, err3;
  assign mux_out3 = mux_in3[sel3];

  mux_sel_sequencer #(.HOLD(1)) u_h1 (
    .clk(clk), .rst(rst), .start(start1), .din(din1), .mux_out(mux_out1),
    .mux_in(mux_in1), .sel(sel1), .busy(busy1), .ser_out(ser_out1),
    .ser_valid(ser_valid1), .word_out(word_out1), .done(done1), .err(err1));

  mux_sel_sequencer #(.HOLD(3)) u_h3 (
    .clk(clk), .rst(rst), .start(start3), .din(din3), .mux_out(mux_out3),
    .mux_in(mux_in3), .sel(sel3), .busy(busy3), .ser_out(ser_out3),
    .ser_valid(ser_valid3), .word_out(word_out3), .done(done3), .err(err3));

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: expected side
  logic       exp_bit[$];
  int         exp_rel[$];
  logic [3:0] exp_word[$];
  // observed side
  logic       vq_bit[$];
  int         vq_rel[$];
  int         dq_rel[$];
  logic [3:0] dq_word[$];
  logic       dq_err[$];
  // per-cycle record, indexed by cycles since the accepting edge (1 = first RUN)
  logic [1:0] rec_sel[64];
  logic [3:0] rec_min[64];
  logic       rec_busy[64];
  logic       rec_err[64];

  // Samples the chosen instance for n cycles. It drives start high for the
  // edges that end cycles pa..pb (din=pdin) and scrambles din otherwise.
  task automatic watch(input bit d3, input int n, input int pa, input int pb,
                       input logic [3:0] pdin);
    vq_bit.delete(); vq_rel.delete();
    dq_rel.delete(); dq_word.delete(); dq_err.delete();
    for (int r = 1; r <= n; r++) begin
      @(negedge clk);
      if (d3) begin
        rec_sel[r] = sel3; rec_min[r] = mux_in3; rec_busy[r] = busy3; rec_err[r] = err3;
        if (ser_valid3) begin vq_bit.push_back(ser_out3); vq_rel.push_back(r); end
        if (done3) begin dq_rel.push_back(r); dq_word.push_back(word_out3); dq_err.push_back(err3); end
        start3 = (r >= pa && r <= pb);
        din3   = start3 ? pdin : 4'($urandom);
      end else begin
        rec_sel[r] = sel1; rec_min[r] = mux_in1; rec_busy[r] = busy1; rec_err[r] = err1;
        if (ser_valid1) begin vq_bit.push_back(ser_out1); vq_rel.push_back(r); end
        if (done1) begin dq_rel.push_back(r); dq_word.push_back(word_out1); dq_err.push_back(err1); end
        start1 = (r >= pa && r <= pb);
        din1   = start1 ? pdin : 4'($urandom);
      end
    end
  endtask

  task automatic push_scan(input logic [3:0] w, input logic [3:0] sample,
                           input int hold, input int base);
    for (int i = 0; i < 4; i++) begin
      exp_bit.push_back(sample[i]);
      exp_rel.push_back(base + (i + 1) * hold + 1);
    end
    exp_word.push_back(w);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({sel1, mux_in1, busy1, ser_out1, ser_valid1, word_out1, done1, err1} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_h1: got sel=%b mux_in=%b busy=%b ser=%b/%b word=%b done=%b err=%b, want all 0",
               sel1, mux_in1, busy1, ser_out1, ser_valid1, word_out1, done1, err1);
    end
    n_checks++;
    if ({sel3, mux_in3, busy3, ser_out3, ser_valid3, word_out3, done3, err3} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_h3: got sel=%b mux_in=%b busy=%b word=%b done=%b err=%b, want all 0",
               sel3, mux_in3, busy3, word_out3, done3, err3);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic eb, ob; int er, orl;
    @(negedge clk); din1 = 4'b1010; start1 = 1'b1;
    push_scan(4'b1010, 4'b1010, 1, 0);
    watch(0, 6, 0, -1, 4'b0);
    for (int r = 1; r <= 4; r++) begin
      n_checks++;
      if (rec_sel[r] !== 2'(r - 1)) begin
        n_fail++; $display("FAIL basic_sel cycle %0d: got %0d want %0d", r, rec_sel[r], r - 1);
      end
    end
    while (exp_bit.size() > 0) begin
      eb = exp_bit.pop_front(); er = exp_rel.pop_front(); n_checks++;
      if (vq_bit.size() == 0) begin
        n_fail++; $display("FAIL basic_sample: got none, want bit %0d at cycle %0d", eb, er);
      end else begin
        ob = vq_bit.pop_front(); orl = vq_rel.pop_front();
        if (ob !== eb || orl != er) begin
          n_fail++; $display("FAIL basic_sample: got %0d at cycle %0d, want %0d at cycle %0d", ob, orl, eb, er);
        end
      end
    end
    n_checks++;
    if (dq_rel.size() != 1 || dq_rel[0] != 5 || dq_word[0] !== exp_word[0] || dq_err[0] !== 1'b0) begin
      n_fail++; $display("FAIL basic_done: got %0d pulses (first cycle %0d word %b err %b), want 1 at cycle 5 word %b err 0",
                         dq_rel.size(), dq_rel.size() ? dq_rel[0] : -1, dq_word.size() ? dq_word[0] : 4'bx,
                         dq_err.size() ? dq_err[0] : 1'bx, exp_word[0]);
    end
    void'(exp_word.pop_front());
    n_checks++;
    if (rec_busy[5] !== 1'b1 || rec_busy[6] !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy: got done-cycle %b idle-cycle %b, want 1 0", rec_busy[5], rec_busy[6]);
    end
  endtask

  task automatic test_err();
    logic eb, ob;
    force0 = 1'b1;
    @(negedge clk); din1 = 4'b1010; start1 = 1'b1;
    push_scan(4'b0000, 4'b0000, 1, 0);
    watch(0, 6, 0, -1, 4'b0);
    while (exp_bit.size() > 0) begin
      eb = exp_bit.pop_front(); void'(exp_rel.pop_front()); n_checks++;
      ob = (vq_bit.size() > 0) ? vq_bit.pop_front() : 1'bx;
      if (ob !== eb) begin n_fail++; $display("FAIL err_sample: got %b want %b", ob, eb); end
    end
    n_checks++;
    if (dq_word.size() != 1 || dq_word[0] !== exp_word[0]) begin
      n_fail++; $display("FAIL err_word: got %b (%0d pulses) want %b", dq_word.size() ? dq_word[0] : 4'bx, dq_word.size(), exp_word[0]);
    end
    void'(exp_word.pop_front());
    // sel=0 sample matches (din[0]=0); sel=1 sample is the first mismatch
    n_checks++;
    if (rec_err[2] !== 1'b0 || rec_err[3] !== 1'b1 || rec_err[6] !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: got cyc2=%b cyc3=%b cyc6=%b want 0 1 1", rec_err[2], rec_err[3], rec_err[6]);
    end
    force0 = 1'b0;
    @(negedge clk); din1 = 4'b1010; start1 = 1'b1;
    watch(0, 6, 0, -1, 4'b0);
    n_checks++;
    if (rec_err[1] !== 1'b0 || dq_word.size() != 1 || dq_word[0] !== 4'b1010 || dq_err[0] !== 1'b0) begin
      n_fail++; $display("FAIL err_clear: got err=%b word=%b, want err 0 word 1010", rec_err[1], dq_word.size() ? dq_word[0] : 4'bx);
    end
  endtask

  task automatic test_hold3();
    logic eb, ob; int er, orl;
    @(negedge clk); din3 = 4'b0110; start3 = 1'b1;
    push_scan(4'b0110, 4'b0110, 3, 0);
    watch(1, 15, 0, -1, 4'b0);
    for (int r = 1; r <= 12; r++) begin
      n_checks++;
      if (rec_sel[r] !== 2'((r - 1) / 3)) begin
        n_fail++; $display("FAIL hold3_sel cycle %0d: got %0d want %0d", r, rec_sel[r], (r - 1) / 3);
      end
    end
    while (exp_bit.size() > 0) begin
      eb = exp_bit.pop_front(); er = exp_rel.pop_front(); n_checks++;
      if (vq_bit.size() == 0) begin
        n_fail++; $display("FAIL hold3_sample: got none, want bit %0d at cycle %0d", eb, er);
      end else begin
        ob = vq_bit.pop_front(); orl = vq_rel.pop_front();
        if (ob !== eb || orl != er) begin
          n_fail++; $display("FAIL hold3_sample: got %0d at cycle %0d, want %0d at cycle %0d", ob, orl, eb, er);
        end
      end
    end
    n_checks++;
    if (dq_rel.size() != 1 || dq_rel[0] != 13 || dq_word[0] !== exp_word[0] || dq_err[0] !== 1'b0) begin
      n_fail++; $display("FAIL hold3_done: got %0d pulses (cycle %0d word %b), want 1 at cycle 13 word %b",
                         dq_rel.size(), dq_rel.size() ? dq_rel[0] : -1, dq_word.size() ? dq_word[0] : 4'bx, exp_word[0]);
    end
    void'(exp_word.pop_front());
    n_checks++;
    if (rec_busy[14] !== 1'b0) begin n_fail++; $display("FAIL hold3_idle: got busy %b want 0", rec_busy[14]); end
  endtask

  task automatic test_ignore_start();
    @(negedge clk); din1 = 4'b0001; start1 = 1'b1;
    exp_word.push_back(4'b0001);
    watch(0, 10, 2, 3, 4'b1111);
    n_checks++;
    if (rec_min[4] !== 4'b0001) begin n_fail++; $display("FAIL ignore_mux_in: got %b want 0001", rec_min[4]); end
    n_checks++;
    if (dq_rel.size() != 1 || dq_rel[0] != 5 || dq_word[0] !== exp_word[0] || dq_err[0] !== 1'b0) begin
      n_fail++; $display("FAIL ignore_done: got %0d pulses (word %b), want 1 at cycle 5 word %b",
                         dq_rel.size(), dq_word.size() ? dq_word[0] : 4'bx, exp_word[0]);
    end
    void'(exp_word.pop_front());
  endtask

  task automatic test_reset_mid();
    logic seen_done = 1'b0;
    @(negedge clk); din1 = 4'b1001; start1 = 1'b1;
    watch(0, 3, 0, -1, 4'b0);
    n_checks++;
    if (rec_sel[3] !== 2'd2) begin n_fail++; $display("FAIL rstmid_sel: got %0d want 2", rec_sel[3]); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({sel1, mux_in1, busy1, ser_out1, ser_valid1, word_out1, done1, err1} !== 15'd0) begin
      n_fail++; $display("FAIL rstmid_async: got sel=%b mux_in=%b busy=%b word=%b done=%b, want all 0",
                         sel1, mux_in1, busy1, word_out1, done1);
    end
    repeat (6) begin @(negedge clk); if (done1) seen_done = 1'b1; end
    n_checks++;
    if (seen_done) begin n_fail++; $display("FAIL rstmid_nodone: got done pulse, want none"); end
    rst = 1'b0;
    @(negedge clk); din1 = 4'b1100; start1 = 1'b1;
    watch(0, 6, 0, -1, 4'b0);
    n_checks++;
    if (dq_word.size() != 1 || dq_word[0] !== 4'b1100 || dq_err[0] !== 1'b0 || dq_rel[0] != 5) begin
      n_fail++; $display("FAIL rstmid_rescan: got word %b err %b, want 1100 0",
                         dq_word.size() ? dq_word[0] : 4'bx, dq_err.size() ? dq_err[0] : 1'bx);
    end
  endtask

  task automatic test_back_to_back();
    logic eb, ob; int er, orl;
    @(negedge clk); din1 = 4'b0101; start1 = 1'b1;
    for (int s = 0; s < 3; s++) push_scan(4'b0101, 4'b0101, 1, 6 * s);
    watch(0, 19, 1, 16, 4'b0101);
    while (exp_bit.size() > 0) begin
      eb = exp_bit.pop_front(); er = exp_rel.pop_front(); n_checks++;
      if (vq_bit.size() == 0) begin
        n_fail++; $display("FAIL b2b_sample: got none, want bit %0d at cycle %0d", eb, er);
      end else begin
        ob = vq_bit.pop_front(); orl = vq_rel.pop_front();
        if (ob !== eb || orl != er) begin
          n_fail++; $display("FAIL b2b_sample: got %0d at cycle %0d, want %0d at cycle %0d", ob, orl, eb, er);
        end
      end
    end
    for (int s = 0; s < 3; s++) begin
      n_checks++;
      if (dq_rel.size() <= s || dq_rel[s] != 6 * s + 5 || dq_word[s] !== exp_word[s]) begin
        n_fail++; $display("FAIL b2b_done %0d: got cycle %0d word %b, want cycle %0d word %b", s,
                           dq_rel.size() > s ? dq_rel[s] : -1, dq_word.size() > s ? dq_word[s] : 4'bx,
                           6 * s + 5, exp_word[s]);
      end
    end
    exp_word.delete();
    n_checks++;
    if (rec_busy[6] !== 1'b0 || rec_busy[7] !== 1'b1 || rec_busy[12] !== 1'b0 || rec_busy[13] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_idle_gap: got busy %b%b %b%b, want 01 01", rec_busy[6], rec_busy[7], rec_busy[12], rec_busy[13]);
    end
    n_checks++;
    if (dq_rel.size() != 3 || rec_busy[19] !== 1'b0) begin
      n_fail++; $display("FAIL b2b_stop: got %0d scans busy-after %b, want 3 scans busy 0", dq_rel.size(), rec_busy[19]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_err();
    test_hold3();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_sel_sequencer.md
MUX_SEL_SEQUENCER -- requirements
Module: mux_sel_sequencer

Interface
REQ-001 Parameter HOLD, default 1, range 1..15: number of clock cycles each select value is held before the mux output is sampled.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to scan a new word; accepted only in IDLE.
REQ-005 din  input  4  parallel word to scan; captured on the accepted start.
REQ-006 mux_out  input  1  output of the external 4:1 mux; combinational from mux_in and sel.
REQ-007 mux_in  output  4  registered copy of the captured din; drives the mux data input.
REQ-008 sel  output  2  registered mux select.
REQ-009 busy  output  1  high in RUN and DONE.
REQ-010 ser_out  output  1  registered sampled mux bit.
REQ-011 ser_valid  output  1  one-cycle pulse qualifying ser_out.
REQ-012 word_out  output  4  reassembled word; bit i is the sample taken at sel=i.
REQ-013 done  output  1  one-cycle pulse marking scan completion.
REQ-014 err  output  1  sticky mismatch flag; high if any sample differed from mux_in[sel].

Function
REQ-015 The FSM SHALL have the states IDLE, RUN and DONE.
- IDLE->RUN on start=1.
- RUN->DONE after the sample at sel=3.
- DONE->IDLE unconditionally.
REQ-016 On the edge accepting start, the block SHALL latch mux_in<=din, set sel<=0, clear the hold counter, clear err, and clear the internal assembly register.
REQ-017 In RUN, the block SHALL hold sel for HOLD cycles and sample mux_out on the edge ending the last hold cycle of each select.
REQ-018 On each sample, the block SHALL set ser_out<=mux_out and ser_valid<=1 for exactly one cycle, and write assembly bit[sel]<=mux_out.
REQ-019 On each sample, the block SHALL set err<=1 if mux_out!=mux_in[sel]; err SHALL then remain 1 until the next accepted start or reset.
REQ-020 After the sample at sel 0, 1 or 2, sel SHALL increment by 1; after the sample at sel=3, sel SHALL wrap to 0 and the state SHALL become DONE.
REQ-021 In the DONE cycle, the block SHALL assert done=1 and word_out SHALL show the full assembly register; word_out SHALL hold its value until the next DONE.
REQ-022 Latency SHALL be as follows for a start accepted at edge k:
- RUN occupies cycles k+1 .. k+4*HOLD.
- DONE is cycle k+4*HOLD+1.
- IDLE resumes at k+4*HOLD+2.
- The final ser_valid pulse coincides with done.
REQ-023 The block SHALL ignore start in RUN and DONE, with no capture and no restart; start held high SHALL begin a new scan on the first IDLE cycle.
REQ-024 din changes after capture SHALL have no effect on mux_in, word_out or err.
REQ-025 The hold counter SHALL be 4 bits wide, count 0..HOLD-1, and reset to 0 on every sel advance.

Reset
REQ-026 While rst=1, asynchronously and independently of clk, the block SHALL enter IDLE and force sel=0, mux_in=0, busy=0, ser_out=0, ser_valid=0, word_out=0, done=0, err=0, hold counter=0.
REQ-027 Reset asserted mid-scan SHALL abort the scan with no done pulse; after rst deasserts, the next start SHALL begin a clean scan.

Verification
REQ-028 HOLD=1, din=1010, ideal mux model, start for one cycle -> sel 0,1,2,3 on consecutive cycles; ser_out 0,1,0,1 each with ser_valid; done at k+5; word_out=1010; err=0.
REQ-029 HOLD=1, din=1010, mux_out forced to 0 -> word_out=0000; err=1 from the sel=1 sample onward; err clears on the next start.
REQ-030 HOLD=3, din=0110 -> each sel value held 3 cycles; 4 ser_valid pulses spaced 3 cycles apart; done at k+13; word_out=0110.
REQ-031 start re-pulsed with din=1111 during RUN of din=0001 -> ignored; word_out=0001; exactly one done pulse.
REQ-032 rst pulsed at sel=2 mid-scan -> all outputs 0 immediately, no done; a following start with din=1100 -> word_out=1100, err=0.
REQ-033 start held high continuously with din=0101 -> back-to-back scans; IDLE lasts one cycle between each DONE and the next RUN; word_out=0101 each time.
